button_event_unit: RTL and testbench
====================================

# button_event_unit

Parametrised multi-channel front end for the seven-segment game buttons. Each channel synchronises a raw pin, debounces it, and produces a clean level plus single-cycle press, release, long-press and auto-repeat events. Sits between `ui_in` and the game FSMs, replacing per-game ad-hoc edge detection. Game logic and game switching consume only the event pulses.

## Interface
- `N_BTN`, 5, number of independent button channels
- `DEBOUNCE_CYCLES`, 10000, consecutive stable cycles required to accept a level change (1 ms at 10 MHz); must be ≥ 1
- `LONG_CYCLES`, 8000000, cycles a debounced press must be held before `long_press`; must be ≥ 1
- `REPEAT_CYCLES`, 2000000, auto-repeat period after a long press; must be ≥ 1
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `btn_raw`  in  N_BTN  raw button pins, asynchronous to `clk`, active high
- `repeat_en`  in  N_BTN  per-channel auto-repeat mode enable, synchronous to `clk`
- `btn_level`  out  N_BTN  debounced button level
- `press`  out  N_BTN  1-cycle pulse on debounced rising edge
- `release`  out  N_BTN  1-cycle pulse on debounced falling edge
- `long_press`  out  N_BTN  1-cycle pulse after the hold time is reached
- `repeat`  out  N_BTN  1-cycle pulse every `REPEAT_CYCLES` while in long-hold with `repeat_en` high
- `any_press`  out  1  OR of all `press` bits, same cycle

## Operation
- Channels are fully independent; no shared state apart from `any_press`.
- Synchroniser: 2 flops per channel (`sync1`, `sync2`).
- Debounce: counter `db_cnt` clears whenever `sync2 == btn_level`. It increments while they differ. When it would reach `DEBOUNCE_CYCLES`, `btn_level` toggles and `db_cnt` clears. A glitch shorter than `DEBOUNCE_CYCLES` cycles at `sync2` never changes `btn_level`.
- Hold FSM per channel:
  - RELEASED → HELD on debounced rise. `press` = 1 that cycle; `hold_cnt` = 0.
  - HELD: `hold_cnt` increments each cycle. When `LONG_CYCLES` cycles have elapsed since the rise, assert `long_press` and go to LONG with `rep_cnt` = 0.
  - LONG: `rep_cnt` increments only while `repeat_en` is high and clears while it is low. When it reaches `REPEAT_CYCLES`, assert `repeat` and clear `rep_cnt`.
  - HELD or LONG → RELEASED on debounced fall. `release` = 1 that cycle; all counters clear.
- Release has priority: no `long_press` or `repeat` is generated in the fall cycle.
- Counters never wrap. `hold_cnt` stops in LONG; `rep_cnt` is bounded by `REPEAT_CYCLES`.
- Counter widths are `$clog2(X+1)` of the respective parameter.
- Parameter violations (value < 1) are caught by an elaboration-time check that stops elaboration.

## Timing
- Reset values: every output, sync flop and counter = 0; FSM = RELEASED. Reset is effective immediately, without waiting for a clock edge.
- Latency: a raw edge stable from clock edge k first appears on `btn_level`, together with its `press`/`release`, at edge k + 2 + `DEBOUNCE_CYCLES`.
- `long_press` occurs `LONG_CYCLES` cycles after `press`.
- First `repeat` occurs `REPEAT_CYCLES` cycles after `long_press` when `repeat_en` is held high; subsequent repeats follow every `REPEAT_CYCLES` cycles.
- All pulses are registered and exactly 1 cycle wide. Events on different channels can fire in the same cycle.
- Reset mid-press: after `rst` falls with the raw pin still high, a full debounce period elapses, then a fresh `press` is generated. No `release` is emitted for the aborted hold.
- `repeat_en` dropped mid-LONG: repeats stop, the channel stays in LONG, and `rep_cnt` restarts from 0 when `repeat_en` returns.

## Structure
- Shared package `seg_games_pkg` holds:
  - the hold-state enum (RELEASED, HELD, LONG, 2 bits);
  - default cycle constants for the 10 MHz board clock.
- Sub-module `button_channel` contains the synchroniser, debounce counter, hold FSM and counters for one pin. The top level generates `N_BTN` instances and ORs the `press` bits into `any_press`.

## Test plan
All scenarios use `N_BTN`=5, `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `REPEAT_CYCLES`=3.
- Clean press and release: `btn_raw[0]` high at edge 10 → `btn_level[0]` and `press[0]` at edge 16; raw low at edge 30 → `release[0]` at edge 36. No `long_press`.
- Glitch rejection: `btn_raw[1]` high for 3 cycles, then low → no level change and no events. A 4-cycle high → one `press`, followed later by one `release`.
- Long press and repeat: `btn_raw[2]` held, `repeat_en[2]`=1 → `press` at t, `long_press` at t+10, `repeat` at t+13, t+16 and t+19. Release → repeats stop and one `release` pulse follows.
- Repeat mode off: same stimulus with `repeat_en[2]`=0 → exactly one `long_press` and zero `repeat` pulses. Raising `repeat_en` 5 cycles later → first `repeat` 3 cycles after the raise.
- Simultaneous channels: `btn_raw[0]` and `btn_raw[4]` rise on the same edge → `press[0]`, `press[4]` and `any_press` all high on the same single cycle.
- Async reset mid-hold: pulse `rst` between clock edges while channel 3 is in LONG → all outputs 0 immediately. With raw still high, the next `press[3]` arrives 6 cycles after `rst` falls, with no `release[3]` beforehand.

Source files
------------

// File: rtl/seg_games_pkg.sv
// Shared definitions for the seven-segment game front end.
//   hold_state_t       : per-button hold FSM encoding
//   BTN_*              : default cycle constants for the 10 MHz board clock
package seg_games_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HELD     = 2'd1,
        LONG     = 2'd2
    } hold_state_t;

    localparam int BTN_COUNT           = 5;
    localparam int BTN_DEBOUNCE_CYCLES = 10_000;     // 1 ms
    localparam int BTN_LONG_CYCLES     = 8_000_000;  // 0.8 s
    localparam int BTN_REPEAT_CYCLES   = 2_000_000;  // 0.2 s

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, hold FSM.
//   clk, rst       : clock, asynchronous active-high reset
//   btn_raw        : raw pin, asynchronous to clk
//   repeat_en      : auto-repeat enable while in long hold
//   btn_level      : debounced level
//   press          : 1-cycle pulse on debounced rise
//   release_pulse  : 1-cycle pulse on debounced fall
//   long_press     : 1-cycle pulse once the hold time is reached
//   repeat_pulse   : 1-cycle pulse every REPEAT_CYCLES in long hold
// release/repeat are reserved words, hence the _pulse suffix.
module button_channel
    import seg_games_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = BTN_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = BTN_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $fatal(1, "button_channel: cycle parameters must be >= 1");
    end

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    // Terminal values are one below the parameter: the event fires on the
    // edge where the count would reach the parameter.
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic          sync1, sync2;
    logic [DW-1:0] db_cnt, db_cnt_nxt;
    logic          level_nxt;
    logic          rise, fall;

    hold_state_t   state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [RW-1:0] rep_cnt, rep_nxt;
    logic          press_nxt, release_nxt, long_nxt, repeat_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            db_cnt        <= '0;
            btn_level     <= 1'b0;
            state         <= RELEASED;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync1         <= btn_raw;
            sync2         <= sync1;
            db_cnt        <= db_cnt_nxt;
            btn_level     <= level_nxt;
            state         <= state_nxt;
            hold_cnt      <= hold_nxt;
            rep_cnt       <= rep_nxt;
            press         <= press_nxt;
            release_pulse <= release_nxt;
            long_press    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
        end
    end

    always_comb begin
        db_cnt_nxt = '0;
        level_nxt  = btn_level;
        if (sync2 != btn_level) begin
            if (db_cnt == DB_LAST) begin
                level_nxt = sync2;
            end else begin
                db_cnt_nxt = db_cnt + 1'b1;
            end
        end
        rise = level_nxt & ~btn_level;
        fall = ~level_nxt & btn_level;
    end

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        rep_nxt     = rep_cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            RELEASED: begin
                if (rise) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                    hold_nxt  = '0;
                    rep_nxt   = '0;
                end
            end
            HELD: begin
                if (fall) begin
                    state_nxt   = RELEASED;
                    release_nxt = 1'b1;
                    hold_nxt    = '0;
                    rep_nxt     = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = LONG;
                        long_nxt  = 1'b1;
                        rep_nxt   = '0;
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    state_nxt   = RELEASED;
                    release_nxt = 1'b1;
                    hold_nxt    = '0;
                    rep_nxt     = '0;
                end else if (!repeat_en) begin
                    rep_nxt = '0;
                end else if (rep_cnt == REP_LAST) begin
                    repeat_nxt = 1'b1;
                    rep_nxt    = '0;
                end else begin
                    rep_nxt = rep_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                hold_nxt  = '0;
                rep_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_event_unit.sv
// Multi-channel button front end: N_BTN independent button_channel
// instances plus a combined press indicator.
//   clk, rst       : clock, asynchronous active-high reset
//   btn_raw        : raw pins, asynchronous to clk
//   repeat_en      : per-channel auto-repeat enable
//   btn_level      : debounced levels
//   press          : per-channel debounced rise pulses
//   release_pulse  : per-channel debounced fall pulses
//   long_press     : per-channel hold-time pulses
//   repeat_pulse   : per-channel auto-repeat pulses
//   any_press      : OR of press, same cycle
module button_event_unit
    import seg_games_pkg::*;
#(
    parameter int N_BTN           = BTN_COUNT,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = BTN_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = BTN_REPEAT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             any_press
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .btn_raw       (btn_raw[i]),
            .repeat_en     (repeat_en[i]),
            .btn_level     (btn_level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

    assign any_press = |press;

endmodule

// File: tb/tb_button_event_unit.sv
module tb_button_event_unit;

    localparam int N = 5;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] repeat_en;
    logic [N-1:0] btn_level;
    logic [N-1:0] press;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_press;
    logic [N-1:0] repeat_pulse;
    logic         any_press;

    button_event_unit #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .repeat_en     (repeat_en),
        .btn_level     (btn_level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .any_press     (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled on the inactive edge.
    int cnt_press [N];
    int cnt_rel   [N];
    int cnt_long  [N];
    int cnt_rep   [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            cnt_press[i] = 0;
            cnt_rel[i]   = 0;
            cnt_long[i]  = 0;
            cnt_rep[i]   = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_press[i] += int'(press[i]);
                cnt_rel[i]   += int'(release_pulse[i]);
                cnt_long[i]  += int'(long_press[i]);
                cnt_rep[i]   += int'(repeat_pulse[i]);
            end
        end
    end

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] ren;
        int unsigned  adv;
        logic [N-1:0] level;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        logic [N-1:0] rep;
        logic         any;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    task automatic add(input logic [N-1:0] raw, input logic [N-1:0] ren,
                       input int unsigned adv, input logic [N-1:0] level,
                       input logic [N-1:0] prs, input logic [N-1:0] rel,
                       input logic [N-1:0] lng, input logic [N-1:0] rep,
                       input logic any);
        vec_t v;
        v.raw = raw; v.ren = ren; v.adv = adv; v.level = level;
        v.prs = prs; v.rel = rel; v.lng = lng; v.rep = rep; v.any = any;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [N-1:0] level, input logic [N-1:0] prs,
                           input logic [N-1:0] rel, input logic [N-1:0] lng,
                           input logic [N-1:0] rep, input logic any);
        chk({nm, ".level"}, btn_level, level);
        chk({nm, ".press"}, press, prs);
        chk({nm, ".release"}, release_pulse, rel);
        chk({nm, ".long"}, long_press, lng);
        chk({nm, ".repeat"}, repeat_pulse, rep);
        chk({nm, ".any"}, {4'b0, any_press}, {4'b0, any});
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    int snap_long, snap_rep, snap_rel;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        btn_raw   = '0;
        repeat_en = '0;

        // Raw edges are driven on the falling edge; a change first sampled
        // at edge P appears on btn_level at edge P+5.
        // A: clean press/release on ch0 (released before the hold time)
        add(5'b00001, 5'b00000, 5, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00001, 5'b00000, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        add(5'b00001, 5'b00000, 1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 5, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        // B: 3-cycle glitch rejected, 4-cycle pulse accepted on ch1
        add(5'b00010, 5'b00000, 3, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 6, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00010, 5'b00000, 4, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 2, 5'b00010, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        add(5'b00000, 5'b00000, 1, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 2, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        // C: ch2 long press with repeat (index 14..23)
        add(5'b00100, 5'b00100, 6, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        add(5'b00100, 5'b00100, 9, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00100, 5'b00100, 1, 5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 1'b0);
        add(5'b00100, 5'b00100, 2, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00100, 5'b00100, 1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 1'b0);
        add(5'b00100, 5'b00100, 3, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 1'b0);
        add(5'b00100, 5'b00100, 3, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 1'b0);
        add(5'b00000, 5'b00100, 3, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 1'b0);
        // fall cycle coincides with a due repeat: release wins
        add(5'b00000, 5'b00100, 3, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        // D: ch2 long press, repeat off, then enabled / dropped / re-enabled (index 24..34)
        add(5'b00100, 5'b00000, 6, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        add(5'b00100, 5'b00000, 10, 5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 1'b0);
        add(5'b00100, 5'b00000, 5, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00100, 5'b00100, 2, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00100, 5'b00100, 1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 1'b0);
        add(5'b00100, 5'b00100, 1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00100, 5'b00000, 4, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00100, 5'b00100, 2, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00100, 5'b00100, 1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 1'b0);
        add(5'b00000, 5'b00000, 6, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        // E: simultaneous ch0 and ch4
        add(5'b10001, 5'b00000, 6, 5'b10001, 5'b10001, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        add(5'b10001, 5'b00000, 1, 5'b10001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        add(5'b00000, 5'b00000, 6, 5'b00000, 5'b00000, 5'b10001, 5'b00000, 5'b00000, 1'b0);

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", '0, '0, '0, '0, '0, 1'b0);
        rst = 1'b0;
        tick(2);
        chk_all("post_reset", '0, '0, '0, '0, '0, 1'b0);

        snap_long = 0; snap_rep = 0;
        for (int unsigned i = 0; i < vecs.size(); i++) begin
            if (i == 14 || i == 24) begin
                snap_long = cnt_long[2];
                snap_rep  = cnt_rep[2];
            end
            btn_raw   = vecs[i].raw;
            repeat_en = vecs[i].ren;
            tick(vecs[i].adv);
            chk_all($sformatf("v%0d", i), vecs[i].level, vecs[i].prs, vecs[i].rel,
                    vecs[i].lng, vecs[i].rep, vecs[i].any);
            if (i == 23) begin
                chk_int("C.long_count", cnt_long[2] - snap_long, 1);
                chk_int("C.repeat_count", cnt_rep[2] - snap_rep, 4);
            end
            if (i == 34) begin
                chk_int("D.long_count", cnt_long[2] - snap_long, 1);
                chk_int("D.repeat_count", cnt_rep[2] - snap_rep, 2);
            end
        end
        chk_int("A.ch0_long_count", cnt_long[0], 0);
        chk_int("B.ch1_press_count", cnt_press[1], 1);
        chk_int("B.ch1_release_count", cnt_rel[1], 1);

        // F: async reset while ch3 is in long hold
        btn_raw = 5'b01000;
        tick(6);
        chk("F.press", press, 5'b01000);
        tick(10);
        chk("F.long", long_press, 5'b01000);
        snap_rel = cnt_rel[3];
        @(posedge clk);
        #1;
        chk("F.level_before_rst", btn_level, 5'b01000);
        #1 rst = 1'b1;
        #1;
        chk_all("F.in_rst", '0, '0, '0, '0, '0, 1'b0);
        #1 rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk_all($sformatf("F.wait%0d", k), '0, '0, '0, '0, '0, 1'b0);
        end
        tick(1);
        chk_all("F.repress", 5'b01000, 5'b01000, '0, '0, '0, 1'b1);
        chk_int("F.no_release", cnt_rel[3] - snap_rel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
